multicycle_control_fsm: RTL
===========================

# multicycle_control_fsm

Sequenced control unit for the multicycle datapath. It takes the instruction opcode and steps through fetch, decode, execute, memory and writeback one state per clock. It drives the datapath mux selects and write strobes, waits on a memory-ready handshake, and counts retired instructions. It sits between the instruction register and the shared ALU, register file and unified memory.

## Interface
- `OPCODE_W`, 6, opcode width
- `CNT_W`, 32, retire counter width
- `OP_RTYPE`, 6'h00, R-type opcode
- `OP_LW`, 6'h23, load word opcode
- `OP_SW`, 6'h2B, store word opcode
- `OP_BEQ`, 6'h04, branch-equal opcode
- `OP_ADDI`, 6'h08, add-immediate opcode
- `OP_J`, 6'h02, jump opcode

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `Opcode`  in  OPCODE_W  IR[31:26]; must be stable from the DECODE state onward
- `MemReady`  in  1  memory completes the current access this cycle
- `IorD`, `IRWrite`, `MemWrite`, `RegDst`, `MemtoReg`, `RegWrite`, `ALUSrcA`, `PCWrite`, `Branch`  out  1  datapath controls
- `ALUSrcB`, `ALUOp`, `PCSrc`  out  2  datapath selects
- `Illegal`  out  1  sticky illegal-opcode flag
- `State`  out  4  current state encoding, for debug
- `RetireCount`  out  CNT_W  instructions retired

## Operation
States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, ILLEGAL=12.

Transitions:
- FETCH→DECODE when `MemReady`=1; otherwise hold in FETCH.
- DECODE branches on `Opcode`:
  - LW or SW → MEMADR
  - RTYPE → EXECUTE
  - BEQ → BRANCH
  - ADDI → ADDIEX
  - J → JUMP
  - any other opcode → ILLEGAL
- MEMADR → MEMRD for LW, MEMWR for SW.
- MEMRD → MEMWB when `MemReady`=1; otherwise hold.
- MEMWR → FETCH when `MemReady`=1; otherwise hold.
- EXECUTE → ALUWB.
- ADDIEX → ADDIWB.
- MEMWB, ALUWB, ADDIWB, BRANCH and JUMP → FETCH.
- ILLEGAL holds until reset. `Illegal`=1 only in this state.
- Unused encodings 13–15 → FETCH.

Outputs are Moore, decoded from state. Any output not listed for a state is 0.
- FETCH: ALUSrcB=01; IRWrite=PCWrite=`MemReady`
- DECODE: ALUSrcB=11
- MEMADR: ALUSrcA=1, ALUSrcB=10
- MEMRD: IorD=1
- MEMWB: MemtoReg=1, RegWrite=1
- MEMWR: IorD=1; MemWrite=1 for every stall cycle
- EXECUTE: ALUSrcA=1, ALUOp=10
- ALUWB: RegDst=1, RegWrite=1
- BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1
- ADDIEX: ALUSrcA=1, ALUSrcB=10
- ADDIWB: RegWrite=1
- JUMP: PCSrc=10, PCWrite=1

Retire counter:
- `RetireCount` increments by 1 on every clock edge that moves the FSM into FETCH from MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH or JUMP.
- It wraps modulo 2^CNT_W without saturating.
- It never increments from ILLEGAL or from an unused encoding.

## Timing
- Reset asserted: state=FETCH, `RetireCount`=0, `Illegal`=0, `State`=0. IRWrite and PCWrite are forced to 0 while `rst_n`=0. ALUSrcB=01 and all other outputs are 0.
- Cycles per instruction with no stalls:
  - LW: 5
  - SW: 4
  - RTYPE: 4
  - ADDI: 4
  - BEQ: 3
  - J: 3
- Each cycle that `MemReady`=0 in FETCH, MEMRD or MEMWR adds one cycle. `MemReady` is ignored in all other states.
- `RetireCount` updates on the same edge that `State` becomes 0.
- If reset is asserted mid-instruction, the FSM returns to FETCH immediately. No partial writeback strobe is issued after `rst_n` falls.

## Configuration
- `MC_JUMP_EN` defined: OP_J decodes to JUMP as specified above.
- `MC_JUMP_EN` undefined:
  - The JUMP state is removed and its encoding 11 is treated as unused.
  - OP_J decodes to ILLEGAL.
  - PCSrc never takes the value 10.

## Test plan
- Reset with `MemReady`=1, then release; `Opcode`=6'h00 → states 0,1,6,7,0; RegDst=RegWrite=1 in ALUWB; `RetireCount`=1.
- LW with `MemReady` low for 3 cycles in MEMRD → 8 cycles total; MemtoReg=1 in MEMWB; IRWrite pulses only on FETCH cycles where `MemReady`=1.
- SW with `MemReady` low for 2 cycles in MEMWR → MemWrite=1 for 3 consecutive cycles, then FETCH; `RetireCount` increments once.
- `Opcode`=6'h3F → ILLEGAL after DECODE; `Illegal` stays 1 for 20 cycles; `RetireCount` is unchanged; `rst_n` low clears it.
- `CNT_W`=4, 16 back-to-back BEQs → `RetireCount` wraps to 0; PCSrc=01 and Branch=1 in every BRANCH cycle.
- J with `MC_JUMP_EN` defined → PCWrite=1 and PCSrc=10 in state 11. With the macro undefined → ILLEGAL.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: sequenced control for the multicycle datapath (fetch/decode/execute/mem/writeback)
// Define MC_JUMP_EN to decode OP_J into the JUMP state; otherwise OP_J is illegal and encoding 11 is unused.
module multicycle_control_fsm #(
    parameter int                  OPCODE_W = 6,
    parameter int                  CNT_W    = 32,
    parameter logic [OPCODE_W-1:0] OP_RTYPE = 6'h00,
    parameter logic [OPCODE_W-1:0] OP_LW    = 6'h23,
    parameter logic [OPCODE_W-1:0] OP_SW    = 6'h2B,
    parameter logic [OPCODE_W-1:0] OP_BEQ   = 6'h04,
    parameter logic [OPCODE_W-1:0] OP_ADDI  = 6'h08,
    parameter logic [OPCODE_W-1:0] OP_J     = 6'h02
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                MemReady,
    output logic                IorD,
    output logic                IRWrite,
    output logic                MemWrite,
    output logic                RegDst,
    output logic                MemtoReg,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic                PCWrite,
    output logic                Branch,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUOp,
    output logic [1:0]          PCSrc,
    output logic                Illegal,
    output logic [3:0]          State,
    output logic [CNT_W-1:0]    RetireCount
);
`ifdef MC_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11,
        ILLEGAL = 4'd12
    } state_t;
    state_t state, nxt;
    logic   retire, jump_q;
    // next state; writeback/branch/jump states and unused encodings all fall back to FETCH
    always_comb begin
        nxt = FETCH;
        case (state)
            FETCH:   nxt = MemReady ? DECODE : FETCH;
            DECODE:  nxt = (Opcode == OP_LW || Opcode == OP_SW) ? MEMADR :
                           Opcode == OP_RTYPE ? EXECUTE :
                           Opcode == OP_BEQ ? BRANCH :
                           Opcode == OP_ADDI ? ADDIEX :
                           (JUMP_EN && Opcode == OP_J) ? JUMP : ILLEGAL;
            MEMADR:  nxt = Opcode == OP_SW ? MEMWR : MEMRD;
            MEMRD:   nxt = MemReady ? MEMWB : MEMRD;
            MEMWR:   nxt = MemReady ? FETCH : MEMWR;
            EXECUTE: nxt = ALUWB;
            ADDIEX:  nxt = ADDIWB;
            ILLEGAL: nxt = ILLEGAL;
            default: nxt = FETCH;
        endcase
    end
    assign retire = nxt == FETCH &&
                    ((state inside {MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH}) || (JUMP_EN && state == JUMP));
    // state register, retire counter and Moore outputs registered from the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            RetireCount <= '0;
            IorD        <= 1'b0;
            MemWrite    <= 1'b0;
            RegDst      <= 1'b0;
            MemtoReg    <= 1'b0;
            RegWrite    <= 1'b0;
            ALUSrcA     <= 1'b0;
            Branch      <= 1'b0;
            jump_q      <= 1'b0;
            ALUSrcB     <= 2'b01;
            ALUOp       <= 2'b00;
            PCSrc       <= 2'b00;
            Illegal     <= 1'b0;
        end else begin
            state       <= nxt;
            RetireCount <= RetireCount + CNT_W'(retire);
            IorD        <= nxt == MEMRD || nxt == MEMWR;
            MemWrite    <= nxt == MEMWR;
            RegDst      <= nxt == ALUWB;
            MemtoReg    <= nxt == MEMWB;
            RegWrite    <= nxt inside {MEMWB, ALUWB, ADDIWB};
            ALUSrcA     <= nxt inside {MEMADR, EXECUTE, BRANCH, ADDIEX};
            Branch      <= nxt == BRANCH;
            jump_q      <= JUMP_EN && nxt == JUMP;
            ALUSrcB     <= nxt == FETCH ? 2'b01 : nxt == DECODE ? 2'b11 :
                           (nxt inside {MEMADR, ADDIEX}) ? 2'b10 : 2'b00;
            ALUOp       <= nxt == EXECUTE ? 2'b10 : nxt == BRANCH ? 2'b01 : 2'b00;
            PCSrc       <= nxt == BRANCH ? 2'b01 : (JUMP_EN && nxt == JUMP) ? 2'b10 : 2'b00;
            Illegal     <= nxt == ILLEGAL;
        end
    end
    // fetch strobes follow the memory handshake in the same cycle and are gated off during reset
    assign IRWrite = rst_n && state == FETCH && MemReady;
    assign PCWrite = IRWrite || jump_q;
    assign State   = state;
endmodule
